inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 22 ++
 rtl/imm_pack.sv | 54 +++++
 rtl/inst_encoder.sv | 104 ++++++++++
 tb/tb_inst_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - shared constants, state type and range helper for the instruction encoder
package inst_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  // True when v is representable as a signed value of msb+1 bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] s;
    s = $signed(v) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - packs instruction fields into a 32-bit word and range-checks the immediate
module imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  i_imm_src,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_legal
);

  always_comb begin
    o_inst  = '0;
    o_legal = 1'b0;
    case (i_imm_src)
      IMM_I: begin
        // Shift forms carry Funct7 and a 5-bit shamt in the immediate slot
        if (i_funct3 == F3_SLL || i_funct3 == F3_SRL) begin
          o_inst  = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
          o_legal = (i_imm[31:5] == '0);
        end else begin
          o_inst  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
          o_legal = fits_signed(i_imm, 11);
        end
      end
      IMM_S: begin
        o_inst  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_legal = fits_signed(i_imm, 11);
      end
      IMM_B: begin
        o_inst  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
        o_legal = fits_signed(i_imm, 12) && !i_imm[0];
      end
      IMM_U: begin
        o_inst  = {i_imm[31:12], i_rd, i_opcode};
        o_legal = (i_imm[11:0] == '0);
      end
      IMM_J: begin
        o_inst  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_legal = fits_signed(i_imm, 20) && !i_imm[0];
      end
      default: begin
        o_inst  = '0;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - instruction encoder with one-entry output register, address counter and error count
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSrc,
  input  logic [6:0]       Opcode,
  input  logic [4:0]       Rd,
  input  logic [2:0]       Funct3,
  input  logic [4:0]       Rs1,
  input  logic [4:0]       Rs2,
  input  logic [6:0]       Funct7,
  input  logic [31:0]      Imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Inst,
  output logic [31:0]      Addr,
  input  logic             Base_load,
  input  logic [31:0]      Base_addr,
  output logic             Err,
  output logic [ERR_W-1:0] ErrCnt
);

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_inst;
  logic [31:0]        r_addr;
  logic [31:0]        r_next_addr;
  logic               r_err;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [31:0]        w_inst;
  logic               w_legal;
  logic               w_accept;
  logic               w_load;
  logic               w_drop;
  logic               w_hs;
  logic [31:0]        w_word_addr;

  imm_pack u_imm_pack (
    .i_imm_src (ImmSrc),
    .i_opcode  (Opcode),
    .i_rd      (Rd),
    .i_funct3  (Funct3),
    .i_rs1     (Rs1),
    .i_rs2     (Rs2),
    .i_funct7  (Funct7),
    .i_imm     (Imm),
    .o_inst    (w_inst),
    .o_legal   (w_legal)
  );

  assign in_ready    = !rst && ((r_state == ST_EMPTY) || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_load      = w_accept && w_legal;
  assign w_drop      = w_accept && !w_legal;
  assign w_hs        = (r_state == ST_FULL) && out_ready;
  // A pending base reload belongs to the word being loaded in the same cycle
  assign w_word_addr = Base_load ? Base_addr : r_next_addr;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_load) w_state_next = ST_FULL;
      ST_FULL:  if (w_load) w_state_next = ST_FULL;
                else if (w_hs) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_inst      <= '0;
      r_addr      <= BASE_ADDR;
      r_next_addr <= BASE_ADDR;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_drop;
      if (w_load) begin
        r_inst      <= w_inst;
        r_addr      <= w_word_addr;
        r_next_addr <= w_word_addr + 32'd4;
      end else if (Base_load) begin
        r_next_addr <= Base_addr;
      end
      if (w_drop && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign Inst      = r_inst;
  assign Addr      = r_addr;
  assign Err       = r_err;
  assign ErrCnt    = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed self-checking bench for inst_encoder
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  ImmSrc = '0;
  logic [6:0]  Opcode = '0;
  logic [4:0]  Rd = '0;
  logic [2:0]  Funct3 = '0;
  logic [4:0]  Rs1 = '0;
  logic [4:0]  Rs2 = '0;
  logic [6:0]  Funct7 = '0;
  logic [31:0] Imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Inst;
  logic [31:0] Addr;
  logic        Base_load = 1'b0;
  logic [31:0] Base_addr = '0;
  logic        Err;
  logic [7:0]  ErrCnt;

  int n_checks = 0;
  int n_pass   = 0;

  inst_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .Opcode(Opcode), .Rd(Rd), .Funct3(Funct3), .Rs1(Rs1),
    .Rs2(Rs2), .Funct7(Funct7), .Imm(Imm), .out_valid(out_valid),
    .out_ready(out_ready), .Inst(Inst), .Addr(Addr), .Base_load(Base_load),
    .Base_addr(Base_addr), .Err(Err), .ErrCnt(ErrCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] f7, input logic [31:0] imm);
    ImmSrc = src; Opcode = op; Rd = rd; Funct3 = f3;
    Rs1 = rs1; Rs2 = rs2; Funct7 = f7; Imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [6:0] f7, input logic [31:0] imm);
    drive(src, op, rd, f3, rs1, rs2, f7, imm);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_addi(input logic [31:0] imm);
    send(3'b000, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, imm);
  endtask

  task automatic send_sw();
    send(3'b001, 7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8);
  endtask

  typedef struct {
    logic [2:0]  src;
    logic [2:0]  f3;
    logic [31:0] imm;
  } bad_t;

  bad_t bad_tab[6];

  initial begin
    bad_tab[0] = '{3'b000, 3'b000, 32'd2048};
    bad_tab[1] = '{3'b000, 3'b001, 32'd32};
    bad_tab[2] = '{3'b010, 3'b000, 32'h1234_5001};
    bad_tab[3] = '{3'b011, 3'b000, 32'd0};
    bad_tab[4] = '{3'b101, 3'b000, 32'd4096};
    bad_tab[5] = '{3'b110, 3'b000, 32'd1};

    #2;
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst Inst", Inst, 32'd0);
    check("rst Addr", Addr, 32'd0);
    check("rst ErrCnt", {24'd0, ErrCnt}, 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    send_addi(32'd5);
    check("addi valid", {31'd0, out_valid}, 32'd1);
    check("addi Inst", Inst, 32'h0050_0093);
    check("addi Addr", Addr, 32'h0);
    send_sw();
    check("sw Inst", Inst, 32'h0020_A423);
    check("sw Addr", Addr, 32'h4);
    send(3'b101, 7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFC);
    check("beq Inst", Inst, 32'hFE00_0EE3);
    check("beq Addr", Addr, 32'h8);
    send(3'b110, 7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd8);
    check("jal Inst", Inst, 32'h0080_00EF);
    check("jal Addr", Addr, 32'hC);
    send(3'b010, 7'b0110111, 5'd5, 3'b000, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    check("lui Inst", Inst, 32'h1234_52B7);
    check("lui Addr", Addr, 32'h10);
    send(3'b000, 7'b0010011, 5'd1, 3'b001, 5'd1, 5'd0, 7'd0, 32'd3);
    check("slli Inst", Inst, 32'h0030_9093);
    send(3'b000, 7'b0010011, 5'd2, 3'b101, 5'd2, 5'd0, 7'b0100000, 32'd31);
    check("srai Inst", Inst, 32'h41F1_5113);
    check("srai Addr", Addr, 32'h18);
    step();
    check("drain valid", {31'd0, out_valid}, 32'd0);

    send(3'b101, 7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'd3);
    check("bodd Err", {31'd0, Err}, 32'd1);
    check("bodd ErrCnt", {24'd0, ErrCnt}, 32'd1);
    check("bodd valid", {31'd0, out_valid}, 32'd0);
    step();
    check("Err pulse end", {31'd0, Err}, 32'd0);
    send_addi(32'd5);
    check("addr held Addr", Addr, 32'h1C);
    send_addi(32'hFFFF_F800);
    check("imin Inst", Inst, 32'h8000_0093);
    check("imin Addr", Addr, 32'h20);
    step();

    for (int i = 0; i < 6; i++) begin
      send(bad_tab[i].src, 7'b0010011, 5'd1, bad_tab[i].f3, 5'd0, 5'd0, 7'd0, bad_tab[i].imm);
      check($sformatf("bad%0d Err", i), {31'd0, Err}, 32'd1);
      check($sformatf("bad%0d ErrCnt", i), {24'd0, ErrCnt}, 32'(2 + i));
      check($sformatf("bad%0d valid", i), {31'd0, out_valid}, 32'd0);
    end

    out_ready = 1'b0;
    send_addi(32'd5);
    check("stall load Addr", Addr, 32'h24);
    drive(3'b001, 7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      check("stall Inst", Inst, 32'h0050_0093);
      check("stall Addr", Addr, 32'h24);
    end
    out_ready = 1'b1;
    step();
    check("release Inst", Inst, 32'h0020_A423);
    check("release Addr", Addr, 32'h28);
    send(3'b110, 7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd8);
    check("b2b valid", {31'd0, out_valid}, 32'd1);
    check("b2b Addr", Addr, 32'h2C);
    step();

    Base_load = 1'b1;
    Base_addr = 32'hFFFF_FFFC;
    step();
    Base_load = 1'b0;
    send_addi(32'd5);
    check("base Addr", Addr, 32'hFFFF_FFFC);
    send_sw();
    check("wrap Addr", Addr, 32'h0);
    send_addi(32'd5);
    send(3'b101, 7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'd3);
    check("full drop valid", {31'd0, out_valid}, 32'd0);
    check("full drop ErrCnt", {24'd0, ErrCnt}, 32'd8);

    drive(3'b011, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd0);
    repeat (300) step();
    in_valid = 1'b0;
    step();
    check("sat ErrCnt", {24'd0, ErrCnt}, 32'd255);

    out_ready = 1'b0;
    send_addi(32'd5);
    check("pre-rst valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid rst valid", {31'd0, out_valid}, 32'd0);
    check("mid rst Inst", Inst, 32'd0);
    check("mid rst Addr", Addr, 32'd0);
    check("mid rst ErrCnt", {24'd0, ErrCnt}, 32'd0);
    check("mid rst in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rel in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("rel valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
